spike_fifo_reader_conv2: RTL and testbench
==========================================

// Module: spike_fifo_reader_conv2
// PURPOSE
//  Read side of the conv1->conv2 spike FIFO. Pops 16-bit synapse-index words,
//  frames them between SOF (16'hF1FA) and EOF (16'hFAF1) markers, and hands each
//  valid channel index to the conv2 weight search over a valid/ready handshake.
//  Reports frame start/done pulses, a per-frame spike count and a sticky error.
// PARAMETERS
//  INDEX_W      16        FIFO word width (= `SYNAPSE_INDEX)
//  CH_W         7         output index width (= `CONV1_CHANNEL_O_WIDE)
//  CHANNEL_NUM  127       highest legal channel index; legal range 1..CHANNEL_NUM
//  SOF_CODE     16'hF1FA  frame-start marker
//  EOF_CODE     16'hFAF1  frame-end marker
//  CNT_W        8         spike_cnt width
// PORTS
//  clk          in   1        clock
//  rstn         in   1        async active-low reset
//  fifo_empty   in   1        spike FIFO empty
//  fifo_dout    in   INDEX_W  FIFO read data, valid 1 cycle after fifo_r_en
//  fifo_r_en    out  1        FIFO pop, 1-cycle pulse
//  s_index_o    out  CH_W     channel index to weight search
//  s_valid      out  1        s_index_o valid
//  s_ready      in   1        weight search accepts index
//  frame_start  out  1        1-cycle pulse on accepted SOF
//  frame_done   out  1        1-cycle pulse on accepted EOF
//  spike_cnt    out  CNT_W    indices sent in current/last frame (saturating)
//  err_flag     out  1        sticky protocol error
//  err_clr      in   1        clears err_flag
// BEHAVIOUR
//  - One clock clk; reset rstn asynchronous, active-low. On reset every output is 0,
//    state=IDLE, in_frame=0. Reset mid-operation drops any popped/pending word.
//  - FSM, registered outputs:
//    IDLE: if !fifo_empty -> RD, else stay.
//    RD:   fifo_r_en=1 (only cycle it is high) -> DEC.
//    DEC:  classify fifo_dout; -> SEND if data accepted into frame, else -> IDLE.
//    SEND: s_valid=1, s_index_o=fifo_dout[CH_W-1:0] held stable; on s_ready -> IDLE,
//          s_valid drops next cycle.
//  - Latency fifo_empty falling -> s_valid rising: 3 clk. Max rate 1 word / 3 clk
//    (+ handshake stall). Never pops while in SEND.
//  - Classification in DEC:
//    SOF, in_frame=0: in_frame<=1, spike_cnt<=0, frame_start pulse.
//    SOF, in_frame=1: err_flag<=1, restart frame (cnt<=0, frame_start pulse).
//    EOF, in_frame=1: in_frame<=0, frame_done pulse; spike_cnt holds until next SOF.
//    EOF, in_frame=0: dropped, err_flag<=1.
//    1..CHANNEL_NUM, in_frame=1: -> SEND; spike_cnt+1 on handshake, sat at all-ones.
//    1..CHANNEL_NUM, in_frame=0: dropped silently (pre-SOF hunt).
//    0 or >CHANNEL_NUM (non-marker), any: dropped, err_flag<=1.
//  - err_flag: set wins over err_clr in the same cycle.
//  - FIFO words are raw 16-bit; only [CH_W-1:0] drive s_index_o after range check.
// STRUCTURE
//  - SOF/EOF codes, CHANNEL_NUM and widths go in the shared define.vh
//    alongside `SYNAPSE_INDEX / `CONV1_CHANNEL_O_WIDE; the conv1 writer uses the same
//    constants.
//  - One combinational sub-module: spike_word_classify (word -> is_sof, is_eof,
//    is_idx, is_bad). FSM, counters and handshake stay in this module.
// TESTING
//  1 Reset: rstn low mid-SEND -> all outputs 0 next edge, s_valid=0, no pop.
//  2 Frame F1FA,0005,007F,FAF1, s_ready=1 -> frame_start, indices 5,127 in order,
//    frame_done, spike_cnt=2, err_flag=0, exactly 4 fifo_r_en pulses.
//  3 Backpressure: s_ready=0 for 10 clk on index 3 -> s_valid/s_index_o=3 stable,
//    no fifo_r_en until handshake.
//  4 Bad words in frame 0000, 0080, F1FA -> each raises err_flag; second F1FA
//    restarts frame with spike_cnt=0; err_clr with new error same cycle -> flag=1.
//  5 Pre-SOF 0009 then FAF1 -> 0009 dropped, no s_valid; FAF1 sets err_flag.
//  6 300 indices in one frame -> spike_cnt saturates at 255.

Source files
------------

// File: rtl/spike_fifo_reader_conv2_pkg.sv
// spike_fifo_reader_conv2_pkg
//   Constants and types shared by the conv1->conv2 spike FIFO reader.
//   The conv1 writer uses the same marker codes and widths.
package spike_fifo_reader_conv2_pkg;

  localparam int SFR_INDEX_W     = 16;   // FIFO word width (synapse index)
  localparam int SFR_CH_W        = 7;    // conv1 output-channel index width
  localparam int SFR_CHANNEL_NUM = 127;  // highest legal channel index
  localparam int SFR_CNT_W       = 8;    // spike counter width

  localparam logic [SFR_INDEX_W-1:0] SFR_SOF_CODE = 16'hF1FA;
  localparam logic [SFR_INDEX_W-1:0] SFR_EOF_CODE = 16'hFAF1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_DEC,
    ST_SEND
  } rd_state_t;

  // Classification of one raw FIFO word; exactly one bit is set.
  typedef struct packed {
    logic is_sof;
    logic is_eof;
    logic is_idx;
    logic is_bad;
  } word_class_t;

endpackage

// File: rtl/spike_word_classify.sv
// spike_word_classify
//   Combinational decode of one raw FIFO word.
//   Ports:
//     word    in  INDEX_W  raw FIFO word
//     is_sof  out 1        word is the frame-start marker
//     is_eof  out 1        word is the frame-end marker
//     is_idx  out 1        word is a legal channel index (1..CHANNEL_NUM)
//     is_bad  out 1        any other value (0 or out of range)
module spike_word_classify
  import spike_fifo_reader_conv2_pkg::*;
#(
  parameter int                  INDEX_W     = SFR_INDEX_W,
  parameter int                  CHANNEL_NUM = SFR_CHANNEL_NUM,
  parameter logic [INDEX_W-1:0]  SOF_CODE    = SFR_SOF_CODE,
  parameter logic [INDEX_W-1:0]  EOF_CODE    = SFR_EOF_CODE
) (
  input  logic [INDEX_W-1:0] word,
  output logic               is_sof,
  output logic               is_eof,
  output logic               is_idx,
  output logic               is_bad
);

  logic in_range;
  logic marker;

  always_comb begin
    is_sof   = (word == SOF_CODE);
    is_eof   = (word == EOF_CODE);
    marker   = is_sof | is_eof;
    // Range check is on the full raw word, so e.g. 16'h1005 is rejected
    // even though its low CH_W bits would look legal.
    in_range = (word != '0) && (word <= INDEX_W'(CHANNEL_NUM));
    is_idx   = !marker && in_range;
    is_bad   = !marker && !in_range;
  end

endmodule

// File: rtl/spike_fifo_reader_conv2.sv
// spike_fifo_reader_conv2
//   Read side of the conv1->conv2 spike FIFO. Pops words one at a time,
//   tracks SOF/EOF framing and forwards in-frame channel indices to the
//   conv2 weight search over a valid/ready handshake.
//   Ports:
//     clk          in  1        clock
//     rstn         in  1        async active-low reset
//     fifo_empty   in  1        spike FIFO empty
//     fifo_dout    in  INDEX_W  FIFO read data, valid 1 cycle after fifo_r_en
//     fifo_r_en    out 1        FIFO pop, 1-cycle pulse
//     s_index_o    out CH_W     channel index to weight search
//     s_valid      out 1        s_index_o valid
//     s_ready      in  1        weight search accepts index
//     frame_start  out 1        pulse on accepted SOF
//     frame_done   out 1        pulse on accepted EOF
//     spike_cnt    out CNT_W    indices sent in current/last frame (saturating)
//     err_flag     out 1        sticky protocol error
//     err_clr      in  1        clears err_flag (a new error in the same cycle wins)
module spike_fifo_reader_conv2
  import spike_fifo_reader_conv2_pkg::*;
#(
  parameter int                  INDEX_W     = SFR_INDEX_W,
  parameter int                  CH_W        = SFR_CH_W,
  parameter int                  CHANNEL_NUM = SFR_CHANNEL_NUM,
  parameter logic [INDEX_W-1:0]  SOF_CODE    = SFR_SOF_CODE,
  parameter logic [INDEX_W-1:0]  EOF_CODE    = SFR_EOF_CODE,
  parameter int                  CNT_W       = SFR_CNT_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               fifo_empty,
  input  logic [INDEX_W-1:0] fifo_dout,
  output logic               fifo_r_en,
  output logic [CH_W-1:0]    s_index_o,
  output logic               s_valid,
  input  logic               s_ready,
  output logic               frame_start,
  output logic               frame_done,
  output logic [CNT_W-1:0]   spike_cnt,
  output logic               err_flag,
  input  logic               err_clr
);

  rd_state_t   state;
  logic        in_frame;
  word_class_t cls;
  logic        err_set;

  spike_word_classify #(
    .INDEX_W     (INDEX_W),
    .CHANNEL_NUM (CHANNEL_NUM),
    .SOF_CODE    (SOF_CODE),
    .EOF_CODE    (EOF_CODE)
  ) u_classify (
    .word   (fifo_dout),
    .is_sof (cls.is_sof),
    .is_eof (cls.is_eof),
    .is_idx (cls.is_idx),
    .is_bad (cls.is_bad)
  );

  // Protocol errors are only judged in DEC, where fifo_dout holds the popped word.
  always_comb begin
    err_set = 1'b0;
    if (state == ST_DEC) begin
      err_set = (cls.is_sof &&  in_frame) ||
                (cls.is_eof && !in_frame) ||
                 cls.is_bad;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      in_frame    <= 1'b0;
      fifo_r_en   <= 1'b0;
      s_index_o   <= '0;
      s_valid     <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      spike_cnt   <= '0;
      err_flag    <= 1'b0;
    end else begin
      fifo_r_en   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;

      if (err_set) begin
        err_flag <= 1'b1;
      end else if (err_clr) begin
        err_flag <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state     <= ST_RD;
            fifo_r_en <= 1'b1;
          end
        end

        ST_RD: begin
          state <= ST_DEC;
        end

        ST_DEC: begin
          state <= ST_IDLE;
          if (cls.is_sof) begin
            // A repeated SOF restarts the frame; the error is raised via err_set.
            in_frame    <= 1'b1;
            spike_cnt   <= '0;
            frame_start <= 1'b1;
          end else if (cls.is_eof) begin
            if (in_frame) begin
              in_frame   <= 1'b0;
              frame_done <= 1'b1;
            end
          end else if (cls.is_idx && in_frame) begin
            state     <= ST_SEND;
            s_valid   <= 1'b1;
            s_index_o <= fifo_dout[CH_W-1:0];
          end
        end

        ST_SEND: begin
          if (s_ready) begin
            state   <= ST_IDLE;
            s_valid <= 1'b0;
            if (!(&spike_cnt)) begin
              spike_cnt <= spike_cnt + 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_fifo_reader_conv2.sv
module tb_spike_fifo_reader_conv2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fifo_empty;
  logic [15:0] fifo_dout = '0;
  logic        fifo_r_en;
  logic [6:0]  s_index_o;
  logic        s_valid;
  logic        s_ready;
  logic        frame_start;
  logic        frame_done;
  logic [7:0]  spike_cnt;
  logic        err_flag;
  logic        err_clr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spike_fifo_reader_conv2 dut (
    .clk         (clk),
    .rstn        (rstn),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .fifo_r_en   (fifo_r_en),
    .s_index_o   (s_index_o),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .spike_cnt   (spike_cnt),
    .err_flag    (err_flag),
    .err_clr     (err_clr)
  );

  // Simple FIFO model: data appears on fifo_dout the edge after fifo_r_en.
  logic [15:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_r_en && (rd_ptr != wr_ptr)) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Event monitor
  int ren_cnt   = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  int valid_cyc = 0;
  int acc_n     = 0;
  int acc [0:1023];

  always @(posedge clk) begin
    if (fifo_r_en)   ren_cnt   <= ren_cnt + 1;
    if (frame_start) start_cnt <= start_cnt + 1;
    if (frame_done)  done_cnt  <= done_cnt + 1;
    if (s_valid)     valid_cyc <= valid_cyc + 1;
    if (s_valid && s_ready) begin
      acc[acc_n] <= int'(s_index_o);
      acc_n      <= acc_n + 1;
    end
  end

  task automatic check_vec(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  // Wait until the FIFO is empty and the reader has been quiet for 4 cycles.
  task automatic drain(input int budget);
    int run = 0;
    int n   = 0;
    while (run < 4 && n < budget) begin
      tick();
      n++;
      if (fifo_empty && !s_valid && !fifo_r_en) run++;
      else run = 0;
    end
    if (run < 4) check_vec("drain_timeout", n, -1);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_vec("err_clr", int'(err_flag), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_ren"},   int'(fifo_r_en),   0);
    check_vec({tag, "_valid"}, int'(s_valid),     0);
    check_vec({tag, "_idx"},   int'(s_index_o),   0);
    check_vec({tag, "_start"}, int'(frame_start), 0);
    check_vec({tag, "_done"},  int'(frame_done),  0);
    check_vec({tag, "_cnt"},   int'(spike_cnt),   0);
    check_vec({tag, "_err"},   int'(err_flag),    0);
  endtask

  int r0, s0, d0, v0, a0, n;

  initial begin
    rstn    = 1'b0;
    s_ready = 1'b0;
    err_clr = 1'b0;
    repeat (3) tick();
    check_all_zero("rst");
    rstn = 1'b1;
    tick();

    // Basic frame: SOF, 5, 127, EOF
    s_ready = 1'b1;
    r0 = ren_cnt; s0 = start_cnt; d0 = done_cnt; a0 = acc_n;
    push(16'hF1FA); push(16'h0005); push(16'h007F); push(16'hFAF1);
    drain(200);
    check_vec("f_start",  start_cnt - s0, 1);
    check_vec("f_done",   done_cnt - d0, 1);
    check_vec("f_nacc",   acc_n - a0, 2);
    check_vec("f_idx0",   acc[a0], 5);
    check_vec("f_idx1",   acc[a0+1], 127);
    check_vec("f_cnt",    int'(spike_cnt), 2);
    check_vec("f_err",    int'(err_flag), 0);
    check_vec("f_pops",   ren_cnt - r0, 4);

    // Latency and backpressure on index 3
    push(16'hF1FA);
    drain(200);
    s_ready = 1'b0;
    a0 = acc_n;
    push(16'h0003); push(16'h0004);
    tick(); tick();
    check_vec("lat_2clk_valid", int'(s_valid), 0);
    tick();
    check_vec("lat_3clk_valid", int'(s_valid), 1);
    check_vec("lat_3clk_idx",   int'(s_index_o), 3);
    r0 = ren_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_vec("bp_valid", int'(s_valid), 1);
      check_vec("bp_idx",   int'(s_index_o), 3);
      check_vec("bp_nopop", ren_cnt - r0, 0);
    end
    s_ready = 1'b1;
    drain(200);
    check_vec("bp_nacc", acc_n - a0, 2);
    check_vec("bp_idx0", acc[a0], 3);
    check_vec("bp_idx1", acc[a0+1], 4);
    check_vec("bp_cnt",  int'(spike_cnt), 2);

    // Bad words in frame
    push(16'h0000);
    drain(200);
    check_vec("bad0_err", int'(err_flag), 1);
    clear_err();
    push(16'h0080);
    drain(200);
    check_vec("bad80_err", int'(err_flag), 1);
    clear_err();
    s0 = start_cnt;
    push(16'hF1FA);
    drain(200);
    check_vec("resof_err",   int'(err_flag), 1);
    check_vec("resof_start", start_cnt - s0, 1);
    check_vec("resof_cnt",   int'(spike_cnt), 0);
    clear_err();
    // New error lands on the same edge as err_clr: set must win.
    push(16'h0000);
    tick(); tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_vec("set_wins", int'(err_flag), 1);
    drain(200);
    clear_err();
    a0 = acc_n; d0 = done_cnt;
    push(16'h0006); push(16'hFAF1);
    drain(200);
    check_vec("rf_nacc", acc_n - a0, 1);
    check_vec("rf_idx",  acc[a0], 6);
    check_vec("rf_done", done_cnt - d0, 1);
    check_vec("rf_cnt",  int'(spike_cnt), 1);
    check_vec("rf_err",  int'(err_flag), 0);

    // Pre-SOF hunt: index dropped silently, stray EOF is an error
    v0 = valid_cyc; d0 = done_cnt;
    push(16'h0009); push(16'hFAF1);
    drain(200);
    check_vec("pre_novalid", valid_cyc - v0, 0);
    check_vec("pre_nodone",  done_cnt - d0, 0);
    check_vec("pre_err",     int'(err_flag), 1);
    check_vec("pre_cnt",     int'(spike_cnt), 1);
    clear_err();

    // Saturation: 300 indices in one frame
    a0 = acc_n; d0 = done_cnt;
    push(16'hF1FA);
    for (int i = 0; i < 300; i++) push(16'((i % 127) + 1));
    push(16'hFAF1);
    drain(5000);
    check_vec("sat_nacc",  acc_n - a0, 300);
    check_vec("sat_first", acc[a0], 1);
    check_vec("sat_last",  acc[a0+299], 46);
    check_vec("sat_cnt",   int'(spike_cnt), 255);
    check_vec("sat_done",  done_cnt - d0, 1);
    check_vec("sat_err",   int'(err_flag), 0);

    // Reset in the middle of SEND
    s_ready = 1'b0;
    push(16'hF1FA); push(16'h0011);
    n = 0;
    while (!s_valid && n < 50) begin
      tick();
      n++;
    end
    check_vec("rs_reach_send", int'(s_valid), 1);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("rs_async");
    r0 = ren_cnt;
    tick();
    check_all_zero("rs_edge");
    tick();
    check_vec("rs_nopop", ren_cnt - r0, 0);
    rstn    = 1'b1;
    s_ready = 1'b1;
    repeat (5) tick();
    check_vec("rs_valid_after", int'(s_valid), 0);
    // in_frame was cleared by reset, so this index is hunted away silently.
    v0 = valid_cyc;
    push(16'h0012);
    drain(200);
    check_vec("rs_noframe_valid", valid_cyc - v0, 0);
    check_vec("rs_noframe_err",   int'(err_flag), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
